// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes, select codes
// and the packed control word the decoder produces.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/control_word_decode.sv
// Purely combinational map from FSM state (plus zero/mem_ready/opcode) to the datapath control word.
// active_i low forces every write enable and illegal_op to 0 while selects keep their state values.
module control_word_decode
    import multicycle_control_fsm_pkg::*;
(
    input  state_t     state_i,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    input  logic       active_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.illegal_op = !op_is_legal(opcode_i);
            end
            MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.mem_write  = 1'b1;
            end
            EXECUTER: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            BEQ: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = zero_i;
            end
            JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = 1'b1;
            end
            default: ctrl_o = '0;
        endcase

        // Reset must never leak a write, even though the state reads FETCH during it.
        if (!active_i) begin
            ctrl_o.ir_write   = 1'b0;
            ctrl_o.pc_write   = 1'b0;
            ctrl_o.reg_write  = 1'b0;
            ctrl_o.mem_write  = 1'b0;
            ctrl_o.illegal_op = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath: state register and next-state logic;
// the per-state control word comes from control_word_decode. mem_ready stretches memory states.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal_op
);

    state_t state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTER;
                    OP_ITYPE:     state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    control_word_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .active_i    (rst_n),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        ALUOp      = ctrl.alu_op;
        ALUSrcA    = ctrl.alu_src_a;
        ALUSrcB    = ctrl.alu_src_b;
        ResultSrc  = ctrl.result_src;
        AdrSrc     = ctrl.adr_src;
        IRWrite    = ctrl.ir_write;
        PCWrite    = ctrl.pc_write;
        RegWrite   = ctrl.reg_write;
        MemWrite   = ctrl.mem_write;
        illegal_op = ctrl.illegal_op;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle and
// compares the full 14-bit control word against hand-computed per-state values.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op;

    int checks = 0;
    int errors = 0;

    // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op}
    localparam logic [13:0] W_FETCH1   = 14'b00_00_10_10_0_11000;
    localparam logic [13:0] W_FETCH0   = 14'b00_00_10_10_0_00000;
    localparam logic [13:0] W_DECODE   = 14'b00_01_01_00_0_00000;
    localparam logic [13:0] W_DEC_ILL  = 14'b00_01_01_00_0_00001;
    localparam logic [13:0] W_MEMADR   = 14'b00_10_01_00_0_00000;
    localparam logic [13:0] W_MEMREAD  = 14'b00_00_00_00_1_00000;
    localparam logic [13:0] W_MEMWB    = 14'b00_00_00_01_0_00100;
    localparam logic [13:0] W_MEMWRITE = 14'b00_00_00_00_1_00010;
    localparam logic [13:0] W_EXECR    = 14'b10_10_00_00_0_00000;
    localparam logic [13:0] W_EXECI    = 14'b10_10_01_00_0_00000;
    localparam logic [13:0] W_ALUWB    = 14'b00_00_00_00_0_00100;
    localparam logic [13:0] W_BEQ_T    = 14'b01_10_00_00_0_01000;
    localparam logic [13:0] W_BEQ_N    = 14'b01_10_00_00_0_00000;
    localparam logic [13:0] W_JAL      = 14'b00_01_10_00_0_01000;

    wire [13:0] ctrl_word = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                             IRWrite, PCWrite, RegWrite, MemWrite, illegal_op};

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUOp      (ALUOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Inputs for the current cycle are already applied; sample mid-cycle, then step one edge.
    task automatic cyc(input string tag, input logic [13:0] exp);
        #2;
        chk(tag, ctrl_word, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'b0110011;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Held in reset with mem_ready=1: FETCH selects, no enables.
        #2 chk("reset_hold", ctrl_word, W_FETCH0);
        rst_n = 1'b1;

        // R-type
        cyc("r_fetch", W_FETCH1);
        cyc("r_decode", W_DECODE);
        cyc("r_exec", W_EXECR);
        cyc("r_aluwb", W_ALUWB);

        // lw with two stall cycles in MEMREAD: 7 cycles total
        opcode = 7'b0000011;
        cyc("lw_fetch", W_FETCH1);
        cyc("lw_decode", W_DECODE);
        cyc("lw_memadr", W_MEMADR);
        mem_ready = 1'b0;
        cyc("lw_rd_wait0", W_MEMREAD);
        cyc("lw_rd_wait1", W_MEMREAD);
        mem_ready = 1'b1;
        cyc("lw_rd_done", W_MEMREAD);
        cyc("lw_memwb", W_MEMWB);

        // sw with three stall cycles: MemWrite high four cycles in a row
        opcode = 7'b0100011;
        cyc("sw_fetch", W_FETCH1);
        cyc("sw_decode", W_DECODE);
        cyc("sw_memadr", W_MEMADR);
        mem_ready = 1'b0;
        cyc("sw_wr0", W_MEMWRITE);
        cyc("sw_wr1", W_MEMWRITE);
        cyc("sw_wr2", W_MEMWRITE);
        mem_ready = 1'b1;
        cyc("sw_wr3", W_MEMWRITE);

        // beq taken, then not taken; both back in FETCH on cycle 4
        opcode = 7'b1100011;
        zero   = 1'b1;
        cyc("beq_t_fetch", W_FETCH1);
        cyc("beq_t_decode", W_DECODE);
        cyc("beq_t_beq", W_BEQ_T);
        zero = 1'b0;
        cyc("beq_n_fetch", W_FETCH1);
        cyc("beq_n_decode", W_DECODE);
        cyc("beq_n_beq", W_BEQ_N);

        // I-type ALU
        opcode = 7'b0010011;
        cyc("i_fetch", W_FETCH1);
        cyc("i_decode", W_DECODE);
        cyc("i_exec", W_EXECI);
        cyc("i_aluwb", W_ALUWB);

        // jal: PC redirect then link writeback
        opcode = 7'b1101111;
        cyc("jal_fetch", W_FETCH1);
        cyc("jal_decode", W_DECODE);
        cyc("jal_jal", W_JAL);
        cyc("jal_aluwb", W_ALUWB);

        // Instruction fetch stall, then illegal opcode
        opcode    = 7'b1111111;
        mem_ready = 1'b0;
        cyc("fetch_stall", W_FETCH0);
        mem_ready = 1'b1;
        cyc("ill_fetch", W_FETCH1);
        cyc("ill_decode", W_DEC_ILL);
        cyc("ill_back_fetch", W_FETCH1);

        // Reset during a stalled MEMWRITE
        opcode = 7'b0100011;
        cyc("rst_sw_decode", W_DECODE);
        cyc("rst_sw_memadr", W_MEMADR);
        mem_ready = 1'b0;
        #2 chk("rst_sw_wr", ctrl_word, W_MEMWRITE);
        rst_n = 1'b0;
        #1 chk("rst_sw_abort", ctrl_word, W_FETCH0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_release_fetch", W_FETCH0);
        mem_ready = 1'b1;
        opcode    = 7'b0110011;
        cyc("rst_after_fetch", W_FETCH1);
        cyc("rst_after_decode", W_DECODE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath mux select and write enable. It sits directly upstream of the ALU control decoder: its `ALUOp` output (00 add, 01 subtract, 10 decode from funct) feeds that decoder every cycle. A `mem_ready` handshake lets the unified instruction/data memory stretch any memory access.

## Interface
Parameters: none. All encodings are fixed constants in the shared package.

Ports:
- `clk`  in  1  — single system clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `opcode`  in  7  — instr[6:0] from the instruction register; valid from DECODE onward.
- `zero`  in  1  — ALU zero flag, same cycle.
- `mem_ready`  in  1  — memory accepted the write or returned the read this cycle.
- `ALUOp`  out  2  — to the ALU control decoder.
- `ALUSrcA`  out  2  — 00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB`  out  2  — 00 rs2, 01 ImmExt, 10 constant 4.
- `ResultSrc`  out  2  — 00 ALUOut, 01 Data, 10 ALUResult.
- `AdrSrc`  out  1  — 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite`  out  1 each  — write enables.
- `illegal_op`  out  1  — one-cycle pulse on an unsupported opcode.

## Operation
- State register only; outputs are a combinational function of the state plus `zero`/`mem_ready` (Moore, except for the gated enables below).
- Undriven selects are 00 / 0 in every state.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are high only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → FETCH, with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Holds until mem_ready=1, then FETCH. MemWrite stays high for every held cycle.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next: ALUWB (writes the link value).
- An unreachable state encoding returns to FETCH on the next edge with all enables 0.

## Timing
- Reset:
  - State becomes FETCH asynchronously.
  - While rst_n=0, IRWrite, PCWrite, RegWrite, MemWrite and illegal_op are forced to 0.
  - Selects and ALUOp show FETCH values.
- First FETCH edge is the first rising clk with rst_n=1.
- Instruction latency in cycles, with mem_ready=1 on its first request:
  - lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, illegal 2.
  - Each cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after rst_n falls.
- ALUOp is valid in the same cycle as the state, so the downstream operation is valid combinationally that cycle.

## Structure
- Shared package holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  - opcode constants
  - ALUOp constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - SrcA, SrcB and ResultSrc select encodings
- One sub-module, `control_word_decode`: purely combinational, state + zero + mem_ready → all outputs. The top holds only the state register and next-state logic.

## Test plan
- Reset held, then released, mem_ready=1, opcode=0110011 → states FETCH, DECODE, EXECUTER, ALUWB. ALUOp=10 in EXECUTER. RegWrite=1 only in cycle 4.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD → 7 total cycles. RegWrite=1 with ResultSrc=01 exactly once.
- sw (0100011), mem_ready=0 for 3 cycles in MEMWRITE → MemWrite high for 4 consecutive cycles. RegWrite never asserts.
- beq with zero=1 and then with zero=0 → BEQ cycle shows ALUOp=01, with PCWrite=1 and 0 respectively. Both cases return to FETCH at cycle 4.
- opcode=1111111 → illegal_op pulses 1 cycle in DECODE, next state FETCH, no enables asserted.
- rst_n dropped during MEMWRITE with mem_ready=0 → MemWrite falls the same cycle. State is FETCH on release.
